// File: rtl/uart_word_arbiter.sv
// uart_word_arbiter
//
// Purpose:
//   Arbitrates between NREQ requesters that each want to send one 64-bit
//   word as eight bytes to a shared downstream byte transmitter. The
//   winner's word and byte order are latched at grant time. The bytes are
//   then offered one at a time over a valid/ready handshake. The owner gets
//   a one-cycle done pulse when its eighth byte is accepted.
//
// Configuration:
//   UART_ARB_ROUND_ROBIN_EN - when defined, the winner is chosen round-robin
//   by searching upward from the requester after the last winner. When it is
//   undefined, the lowest-index requester wins (fixed priority).
//
// Ports:
//   clk        - rising-edge clock for all state
//   rst_n      - asynchronous active-low reset
//   req        - per-requester send request, held until its done pulse
//   word       - flattened words, requester i at [64*i+63:64*i]
//   big_endian - 1: byte [63:56] first, 0: byte [7:0] first
//   grant      - one-hot owner of the current transfer, zero when idle
//   done       - one-cycle pulse to the owner on its last accepted byte
//   tx_valid   - byte available to the downstream transmitter
//   tx_data    - byte presented with tx_valid
//   tx_ready   - downstream accepts tx_data when tx_valid is high
//   busy       - high while a word is being sent

module uart_word_arbiter #(
    parameter int NREQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*64-1:0] word,
    input  logic               big_endian,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    input  logic               tx_ready,
    output logic               busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [2:0]      count, count_next;
    logic [NREQ-1:0] grant_q, grant_next;
    logic [NREQ-1:0] done_q, done_next;
    logic [63:0]     word_q, word_next;
    logic            big_q, big_next;

    logic            win_found;
    logic [IDXW-1:0] win_idx;
    logic [63:0]     win_word;
    logic [2:0]      byte_sel;

`ifdef UART_ARB_ROUND_ROBIN_EN
    logic [IDXW-1:0] last_q, last_next;
`endif

    // Winner selection. Both loops scan from the lowest-priority candidate
    // to the highest, so the last match that gets written is the winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_word  = '0;
`ifdef UART_ARB_ROUND_ROBIN_EN
        for (int k = NREQ; k >= 1; k--) begin
            int cand;
            cand = (int'(last_q) + k) % NREQ;
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = IDXW'(cand);
            end
        end
`else
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = IDXW'(i);
            end
        end
`endif
        win_word = word[64*int'(win_idx) +: 64];
    end

    // Next-state logic. A grant is held off while done is still high, so
    // there is always at least one idle cycle between two words.
    always_comb begin
        state_next = state;
        count_next = count;
        grant_next = grant_q;
        done_next  = '0;
        word_next  = word_q;
        big_next   = big_q;
`ifdef UART_ARB_ROUND_ROBIN_EN
        last_next  = last_q;
`endif
        case (state)
            IDLE: begin
                if ((done_q == '0) && win_found) begin
                    state_next = SEND;
                    count_next = 3'd0;
                    grant_next = NREQ'(1) << win_idx;
                    word_next  = win_word;
                    big_next   = big_endian;
`ifdef UART_ARB_ROUND_ROBIN_EN
                    last_next  = win_idx;
`endif
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (count == 3'd7) begin
                        state_next = IDLE;
                        count_next = 3'd0;
                        done_next  = grant_q;
                        grant_next = '0;
                    end else begin
                        count_next = count + 3'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register. Reset drops any partial word without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= 3'd0;
            grant_q <= '0;
            done_q  <= '0;
            word_q  <= '0;
            big_q   <= 1'b0;
`ifdef UART_ARB_ROUND_ROBIN_EN
            last_q  <= IDXW'(NREQ - 1);
`endif
        end else begin
            state   <= state_next;
            count   <= count_next;
            grant_q <= grant_next;
            done_q  <= done_next;
            word_q  <= word_next;
            big_q   <= big_next;
`ifdef UART_ARB_ROUND_ROBIN_EN
            last_q  <= last_next;
`endif
        end
    end

    // The outputs come straight from registers. tx_data is forced to zero
    // while idle so that the stale latched word is never visible.
    assign byte_sel = big_q ? (3'd7 - count) : count;
    assign busy     = (state == SEND);
    assign tx_valid = busy;
    assign tx_data  = busy ? word_q[{byte_sel, 3'b000} +: 8] : 8'h00;
    assign grant    = grant_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_word_arbiter.sv
module tb_uart_word_arbiter;

    localparam int NREQ = 4;
`ifdef UART_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*64-1:0] word;
    logic               big_endian;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               tx_valid;
    logic [7:0]         tx_data;
    logic               tx_ready;
    logic               busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int m_last       = NREQ - 1;

    uart_word_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .word       (word),
        .big_endian (big_endian),
        .grant      (grant),
        .done       (done),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: the byte stream in send order, first byte at [7:0].
    function automatic logic [63:0] exp_stream(input logic [63:0] w, input logic be);
        logic [63:0] r;
        r = '0;
        for (int n = 0; n < 8; n++) begin
            r[8*n +: 8] = be ? w[8*(7-n) +: 8] : w[8*n +: 8];
        end
        return r;
    endfunction

    // Reference: the first requesting index, starting after last (round
    // robin) or from zero (fixed priority).
    function automatic int pick(input logic [NREQ-1:0] r, input int last);
        int start;
        start = RR_EN ? last + 1 : 0;
        for (int k = 0; k < NREQ; k++) begin
            if (r[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        if (i >= 0 && i < NREQ) v[i] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [63:0] w);
        word[64*i +: 64] = w;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = '0;
        tx_ready = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
        m_last = NREQ - 1;
        step();
    endtask

    // Waits for a grant, then drives tx_ready (0: always, 1: toggle starting
    // low, 2: random) and records the accepted bytes until busy drops.
    // It returns in the done cycle.
    task automatic collect(input int mode, output logic [63:0] bytes, output int nbytes,
                           output logic [NREQ-1:0] owner, output logic [NREQ-1:0] done_seen,
                           output int cycles, output int lat, output bit unstable,
                           output bit timeout);
        bit       prev_stall;
        logic [7:0] prev_data;
        bytes = '0; nbytes = 0; owner = '0; done_seen = '0;
        cycles = 0; lat = 0; unstable = 1'b0; timeout = 1'b0;
        prev_stall = 1'b0; prev_data = 8'h00;
        while (!busy && lat < 20) begin
            step();
            lat++;
        end
        if (!busy) begin
            timeout = 1'b1;
            return;
        end
        owner = grant;
        while (busy && cycles < 300) begin
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) unstable = 1'b1;
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cycles % 2 == 1);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (tx_valid && tx_ready) begin
                if (nbytes < 8) bytes[8*nbytes +: 8] = tx_data;
                nbytes++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            step();
            cycles++;
        end
        if (busy) timeout = 1'b1;
        done_seen = done;
        tx_ready  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '1;
        tx_ready = 1'b1;
        big_endian = 1'b1;
        step();
        step();
        tests_run++;
        if (grant !== '0) begin tests_failed++; $display("[TB] FAIL reset_grant: got %0h expected 0", grant); end
        tests_run++;
        if (done !== '0) begin tests_failed++; $display("[TB] FAIL reset_done: got %0h expected 0", done); end
        tests_run++;
        if (tx_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tx_valid: got %0b expected 0", tx_valid); end
        tests_run++;
        if (tx_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_tx_data: got %0h expected 0", tx_data); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        req = '0;
        tx_ready = 1'b0;
        rst_n = 1'b1;
        m_last = NREQ - 1;
        step();
        step();
        tests_run++;
        if ({busy, tx_valid, grant, done} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL idle_no_req: got busy=%0b valid=%0b grant=%0h done=%0h expected all 0",
                     busy, tx_valid, grant, done);
        end
    endtask

    task automatic test_big_endian();
        logic [63:0] b; int n, cyc, lat; logic [NREQ-1:0] own, dn; bit uns, to;
        do_reset();
        set_word(0, 64'h0102030405060708);
        big_endian = 1'b1;
        req = onehot(0);
        collect(0, b, n, own, dn, cyc, lat, uns, to);
        tests_run++;
        if (to) begin tests_failed++; $display("[TB] FAIL be_timeout: got timeout expected completion"); end
        tests_run++;
        if (lat != 1) begin tests_failed++; $display("[TB] FAIL be_latency: got %0d expected 1", lat); end
        tests_run++;
        if (own !== onehot(pick(onehot(0), m_last))) begin tests_failed++; $display("[TB] FAIL be_grant: got %0h expected 1", own); end
        tests_run++;
        if (b !== 64'h0807060504030201) begin tests_failed++; $display("[TB] FAIL be_bytes: got %016h expected 0807060504030201", b); end
        tests_run++;
        if (n != 8 || cyc != 8) begin tests_failed++; $display("[TB] FAIL be_count: got %0d bytes in %0d cycles expected 8 in 8", n, cyc); end
        tests_run++;
        if (dn !== onehot(0)) begin tests_failed++; $display("[TB] FAIL be_done: got %0h expected 1", dn); end
        m_last = 0;
        req = '0;
        step();
        tests_run++;
        if (done !== '0) begin tests_failed++; $display("[TB] FAIL be_done_width: got %0h expected 0", done); end
    endtask

    task automatic test_little_stall();
        logic [63:0] b; int n, cyc, lat; logic [NREQ-1:0] own, dn; bit uns, to;
        do_reset();
        set_word(0, 64'h0102030405060708);
        big_endian = 1'b0;
        req = onehot(0);
        collect(1, b, n, own, dn, cyc, lat, uns, to);
        tests_run++;
        if (to) begin tests_failed++; $display("[TB] FAIL le_timeout: got timeout expected completion"); end
        tests_run++;
        if (b !== 64'h0102030405060708) begin tests_failed++; $display("[TB] FAIL le_bytes: got %016h expected 0102030405060708", b); end
        tests_run++;
        if (cyc != 16 || n != 8) begin tests_failed++; $display("[TB] FAIL le_cycles: got %0d cycles %0d bytes expected 16 and 8", cyc, n); end
        tests_run++;
        if (uns) begin tests_failed++; $display("[TB] FAIL le_stable: got change during stall expected stable"); end
        tests_run++;
        if (dn !== onehot(0)) begin tests_failed++; $display("[TB] FAIL le_done: got %0h expected 1", dn); end
        req = '0;
        step();
    endtask

    task automatic test_arbitration();
        logic [63:0] b; int n, cyc, lat, exp; logic [NREQ-1:0] own, dn; bit uns, to;
        logic [63:0] w;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_word(i, {$urandom, $urandom});
        req = '1;
        for (int t = 0; t < 5; t++) begin
            big_endian = 1'($urandom_range(0, 1));
            exp = pick(req, m_last);
            w = word[64*exp +: 64];
            collect(0, b, n, own, dn, cyc, lat, uns, to);
            tests_run++;
            if (own !== onehot(exp) || to) begin
                tests_failed++;
                $display("[TB] FAIL arb_grant_%0d: got %0h expected %0h", t, own, onehot(exp));
            end
            tests_run++;
            if (b !== exp_stream(w, big_endian) || n != 8) begin
                tests_failed++;
                $display("[TB] FAIL arb_bytes_%0d: got %016h (%0d) expected %016h (8)", t, b, n, exp_stream(w, big_endian));
            end
            tests_run++;
            if (dn !== onehot(exp) || grant !== '0) begin
                tests_failed++;
                $display("[TB] FAIL arb_done_%0d: got done=%0h grant=%0h expected done=%0h grant=0", t, dn, grant, onehot(exp));
            end
            if (t > 0) begin
                tests_run++;
                if (lat > 2) begin tests_failed++; $display("[TB] FAIL arb_gap_%0d: got %0d expected at most 2", t, lat); end
            end
            m_last = exp;
        end
        req = '0;
        step();
    endtask

    task automatic test_latch_isolation();
        logic [63:0] w, got; logic be; int n, cyc, g; bit any_busy;
        do_reset();
        w = {$urandom, $urandom};
        be = 1'($urandom_range(0, 1));
        set_word(0, w);
        big_endian = be;
        req = onehot(0);
        g = 0;
        while (!busy && g < 20) begin step(); g++; end
        got = '0; n = 0; cyc = 0;
        while (busy && cyc < 100) begin
            tx_ready = 1'b1;
            if (tx_valid) begin
                if (n < 8) got[8*n +: 8] = tx_data;
                n++;
            end
            step();
            cyc++;
            if (n == 1) begin
                set_word(0, ~w);
                big_endian = ~be;
            end
            if (n == 3) req[0] = 1'b0;
        end
        tx_ready = 1'b0;
        tests_run++;
        if (got !== exp_stream(w, be) || n != 8) begin
            tests_failed++;
            $display("[TB] FAIL latch_bytes: got %016h (%0d) expected %016h (8)", got, n, exp_stream(w, be));
        end
        tests_run++;
        if (done !== onehot(0)) begin tests_failed++; $display("[TB] FAIL latch_done: got %0h expected 1", done); end
        any_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (busy || grant !== '0) any_busy = 1'b1;
        end
        tests_run++;
        if (any_busy) begin tests_failed++; $display("[TB] FAIL latch_no_regrant: got new grant expected none"); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] w, b; logic be; int n, cyc, lat, g; logic [NREQ-1:0] own, dn; bit uns, to;
        do_reset();
        w = {$urandom, $urandom};
        be = 1'($urandom_range(0, 1));
        set_word(2, w);
        big_endian = be;
        req = onehot(2);
        g = 0;
        while (!busy && g < 20) begin step(); g++; end
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        tx_ready = 1'b0;
        tests_run++;
        if (tx_data !== exp_stream(w, be)[47:40]) begin
            tests_failed++;
            $display("[TB] FAIL mid_byte5: got %02h expected %02h", tx_data, exp_stream(w, be)[47:40]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, tx_valid, grant, done, tx_data} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL mid_async_reset: got busy=%0b valid=%0b grant=%0h done=%0h data=%02h expected all 0",
                     busy, tx_valid, grant, done, tx_data);
        end
        step();
        step();
        tests_run++;
        if (done !== '0) begin tests_failed++; $display("[TB] FAIL mid_no_done: got %0h expected 0", done); end
        rst_n = 1'b1;
        m_last = NREQ - 1;
        collect(0, b, n, own, dn, cyc, lat, uns, to);
        tests_run++;
        if (own !== onehot(pick(onehot(2), m_last)) || to) begin
            tests_failed++;
            $display("[TB] FAIL mid_regrant: got %0h expected %0h", own, onehot(2));
        end
        tests_run++;
        if (b !== exp_stream(w, be) || n != 8 || dn !== onehot(2)) begin
            tests_failed++;
            $display("[TB] FAIL mid_fresh_word: got %016h n=%0d done=%0h expected %016h n=8 done=%0h",
                     b, n, dn, exp_stream(w, be), onehot(2));
        end
        m_last = 2;
        req = '0;
        step();
    endtask

    task automatic test_random();
        logic [63:0] b, w; int n, cyc, lat, exp; logic [NREQ-1:0] own, dn; bit uns, to;
        do_reset();
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < NREQ; i++) set_word(i, {$urandom, $urandom});
            big_endian = 1'($urandom_range(0, 1));
            req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            exp = pick(req, m_last);
            w = word[64*exp +: 64];
            collect(2, b, n, own, dn, cyc, lat, uns, to);
            tests_run++;
            if (to || own !== onehot(exp) || dn !== onehot(exp)) begin
                tests_failed++;
                $display("[TB] FAIL rand_owner_%0d: got grant=%0h done=%0h timeout=%0b expected %0h (req %0h)",
                         t, own, dn, to, onehot(exp), req);
            end
            tests_run++;
            if (b !== exp_stream(w, big_endian) || n != 8 || uns) begin
                tests_failed++;
                $display("[TB] FAIL rand_bytes_%0d: got %016h n=%0d unstable=%0b expected %016h n=8",
                         t, b, n, uns, exp_stream(w, big_endian));
            end
            m_last = exp;
        end
        req = '0;
        step();
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        word       = '0;
        big_endian = 1'b0;
        tx_ready   = 1'b0;
        test_reset();
        test_big_endian();
        test_little_stall();
        test_arbitration();
        test_latch_isolation();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_word_arbiter.md
UART_WORD_ARBITER -- requirements
Module: uart_word_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters (2..8).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  NREQ  per-requester word-send request; held high until matching done pulse.
REQ-005 Port: word  input  NREQ*64  flattened words; requester i occupies bits [64*i+63:64*i].
REQ-006 Port: big_endian  input  1  1: byte [63:56] sent first; 0: byte [7:0] sent first.
REQ-007 Port: grant  output  NREQ  one-hot owner of the current transfer, all-zero when idle.
REQ-008 Port: done  output  NREQ  one-cycle pulse to the owner when its last byte is accepted.
REQ-009 Port: tx_valid  output  1  byte available to the downstream byte transmitter.
REQ-010 Port: tx_data  output  8  byte presented with tx_valid.
REQ-011 Port: tx_ready  input  1  downstream accepts tx_data this cycle when tx_valid is high.
REQ-012 Port: busy  output  1  high in SEND state.

Function
REQ-013 States SHALL be IDLE and SEND only.
REQ-014 IDLE: if done is zero and req is nonzero at a clock edge, the block SHALL pick a winner, latch its 64-bit word and big_endian, set grant to the winner's one-hot, clear byte counter, and enter SEND.
REQ-015 IDLE with req all-zero SHALL remain in IDLE with all outputs zero.
REQ-016 Latency: req sampled high in IDLE at edge N SHALL give grant and tx_valid high from edge N (registered outputs, visible cycle after N).
REQ-017 SEND: tx_valid SHALL be 1; tx_data SHALL be byte k of the latched word (k = counter for little, 7-counter for big).
REQ-018 tx_data and tx_valid SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-019 Handshake tx_valid&tx_ready with counter<7 SHALL increment the 3-bit counter; no other event advances it.
REQ-020 Handshake with counter==7 SHALL pulse done[winner] for exactly one cycle, clear grant and tx_valid, and return to IDLE.
REQ-021 The cycle in which done is high SHALL NOT start a new grant; minimum one idle cycle between words.
REQ-022 Changes to req, word or big_endian during SEND SHALL NOT affect the transfer in progress (latched at grant).
REQ-023 Requester deasserting req mid-transfer SHALL NOT abort; its word is completed and done still pulses.
REQ-024 busy SHALL equal (state==SEND).
REQ-025 Exactly 8 handshakes per grant; never more, never fewer.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, counter 0, grant 0, done 0, tx_valid 0, tx_data 0, busy 0, last-winner pointer NREQ-1.
REQ-027 Reset asserted mid-transfer SHALL drop the partial word without a done pulse; after release, arbitration restarts as from power-up.

Configuration
REQ-028 Macro UART_ARB_ROUND_ROBIN_EN defined: winner SHALL be the first requester with req high searching upward (mod NREQ) from last-winner+1; last-winner updates at each grant.
REQ-029 Macro undefined: winner SHALL be the lowest-index requester with req high (fixed priority); last-winner pointer unused.

Verification
REQ-030 Single req[0], word=64'h0102030405060708, big_endian=1, tx_ready=1 -> tx_data 01..08 on 8 consecutive cycles, done[0] pulse with byte 08 accepted.
REQ-031 Same word, big_endian=0, tx_ready toggled 1/0 each cycle -> 08,07..01, each byte held stable across stall cycles, 16 cycles in SEND.
REQ-032 req=4'b1111 held, round-robin enabled -> grant order 0,1,2,3,0; macro undefined -> grant 0 every time.
REQ-033 Change word[0] and big_endian after grant, drop req[0] at byte 3 -> original 8 bytes sent, done[0] pulses, no new grant.
REQ-034 rst_n low during byte 5 -> outputs zero asynchronously, no done; after release, req[2] alone -> fresh 8-byte transfer to 2.
REQ-035 done cycle with req still high -> grant 0 that cycle, new grant next cycle.
